// File: rtl/cordic_pkg.sv
// cordic_pkg: shared FSM encoding, CORDIC gain and arctangent constants (32 fractional bits)
package cordic_pkg;

   typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

   localparam logic [31:0] K_Q32 = 32'h9B74EDA8;

   localparam logic [31:0] ATAN_Q32 [32] = '{
      32'hC90FDAA2, 32'h76B19C16, 32'h3EB6EBF2, 32'h1FD5BA9B,
      32'h0FFAADDC, 32'h07FF556F, 32'h03FFEAAB, 32'h01FFFD55,
      32'h00FFFFAB, 32'h007FFFF5, 32'h003FFFFF, 32'h00200000,
      32'h00100000, 32'h00080000, 32'h00040000, 32'h00020000,
      32'h00010000, 32'h00008000, 32'h00004000, 32'h00002000,
      32'h00001000, 32'h00000800, 32'h00000400, 32'h00000200,
      32'h00000100, 32'h00000080, 32'h00000040, 32'h00000020,
      32'h00000010, 32'h00000008, 32'h00000004, 32'h00000002
   };

   // Round-to-nearest rescale of a Q32 fraction to frac fractional bits
   function automatic logic [63:0] q32_round(input logic [31:0] v, input int frac);
      logic [63:0] w;
      w = {32'd0, v};
      if (frac >= 32) return w << (frac - 32);
      return (w + (64'd1 << (31 - frac))) >> (32 - frac);
   endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: atan(2^-idx) in the unit's fixed-point format, built at elaboration
module cordic_atan_rom
   import cordic_pkg::*;
#(
   parameter int WIDTH = 24
) (
   input  logic [4:0]       idx,
   output logic [WIDTH+1:0] atan
);

   logic [WIDTH+1:0] rom [32];

   for (genvar g = 0; g < 32; g++) begin : g_rom
      localparam logic [63:0] V = q32_round(ATAN_Q32[g], WIDTH - 2);
      assign rom[g] = V[WIDTH+1:0];
   end

   assign atan = rom[idx];

endmodule

// File: rtl/cordic_cos_unit.sv
// cordic_cos_unit: iterative rotation-mode CORDIC returning cos/sin of a clamped Q2 angle,
// one micro-rotation per cycle behind a valid/ready handshake on each side.
module cordic_cos_unit
   import cordic_pkg::*;
#(
   parameter int WIDTH      = 24,
   parameter int ITERATIONS = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_angle,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_cos,
   output logic [WIDTH-1:0] out_sin,
   output logic             out_sat
);

   localparam int W = WIDTH + 2;
   localparam logic [63:0] K_FULL = q32_round(K_Q32, WIDTH - 2);
   localparam logic signed [W-1:0] K = K_FULL[W-1:0];
   localparam logic signed [WIDTH-1:0] ONE = {2'b01, {(WIDTH-2){1'b0}}};
   localparam logic signed [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [W-1:0] WMAX = {3'b000, {(WIDTH-1){1'b1}}};

   if (ITERATIONS < 4 || ITERATIONS > WIDTH - 2 || WIDTH > 34) begin : g_bad_params
      $error("cordic_cos_unit: ITERATIONS must lie in 4..WIDTH-2 and WIDTH must not exceed 34");
   end

   state_t state, state_nx;
   logic signed [W-1:0] x, y, z, x_nx, y_nx, z_nx, xs, ys, atan_i;
   logic signed [WIDTH-1:0] ang, ang_c;
   logic [4:0] cnt;
   logic hi, lo, neg, last, sat;

   function automatic logic [WIDTH-1:0] trunc_sat(input logic signed [W-1:0] v);
      return v > WMAX ? MAX : v < -WMAX ? -MAX : v[WIDTH-1:0];
   endfunction

   cordic_atan_rom #(.WIDTH(WIDTH)) u_rom (
      .idx  (cnt),
      .atan (atan_i)
   );

   assign ang   = $signed(in_angle);
   assign hi    = ang > ONE;
   assign lo    = ang < -ONE;
   assign ang_c = hi ? ONE : lo ? -ONE : ang;

   // Direction follows the sign of the residual angle
   assign neg  = z[W-1];
   assign xs   = x >>> cnt;
   assign ys   = y >>> cnt;
   assign x_nx = neg ? x + ys : x - ys;
   assign y_nx = neg ? y - xs : y + xs;
   assign z_nx = neg ? z + atan_i : z - atan_i;
   assign last = cnt == 5'(ITERATIONS - 1);

   always_comb begin
      state_nx  = state;
      in_ready  = state == IDLE;
      out_valid = state == DONE;
      if (in_ready && in_valid) state_nx = ROTATE;
      else if (state == ROTATE && last) state_nx = DONE;
      else if (out_valid && out_ready) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         x       <= '0;
         y       <= '0;
         z       <= '0;
         cnt     <= '0;
         sat     <= 1'b0;
         out_cos <= '0;
         out_sin <= '0;
         out_sat <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && in_valid) begin
            x   <= K;
            y   <= '0;
            z   <= {{2{ang_c[WIDTH-1]}}, ang_c};
            cnt <= '0;
            sat <= hi || lo;
         end else if (state == ROTATE) begin
            x   <= x_nx;
            y   <= y_nx;
            z   <= z_nx;
            cnt <= cnt + 5'd1;
            // Results are published on the final rotation edge, together with the move to DONE
            if (last) begin
               out_cos <= trunc_sat(x_nx);
               out_sin <= trunc_sat(y_nx);
               out_sat <= sat;
            end
         end
      end
   end

endmodule

// File: tb/tb_cordic_cos_unit.sv
// tb_cordic_cos_unit: random and directed angles checked against a real-valued cos/sin model.
module tb_cordic_cos_unit;

   localparam int  WIDTH = 24;
   localparam int  ITER  = 20;
   localparam int  ONE_I = 4194304;
   localparam real SCALE = 4194304.0;
   localparam real TOL   = 32.0;

   logic clk = 0, reset_n = 0, in_valid = 0, out_ready = 1;
   logic [WIDTH-1:0] in_angle = '0;
   logic in_ready, out_valid, out_sat;
   logic [WIDTH-1:0] out_cos, out_sin;

   int n_tests = 0, n_fail = 0;

   typedef struct {
      real c;
      real s;
      bit  sat;
      int  t;
      bit  lit;
      int  lc;
      int  ls;
   } exp_t;

   exp_t q[$];
   bit lit_en = 0, b2b = 0, done_flag = 0;
   int lit_c = 0, lit_s = 0;

   always #5 clk = ~clk;

   cordic_cos_unit #(.WIDTH(WIDTH), .ITERATIONS(ITER)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_angle  (in_angle),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_cos   (out_cos),
      .out_sin   (out_sin),
      .out_sat   (out_sat)
   );

   function automatic void check(input string name, input bit ok, input string got, input string want);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %s, expected %s", name, got, want);
      end
   endfunction

   function automatic int sv(input logic [WIDTH-1:0] v);
      return int'($signed(v));
   endfunction

   function automatic bit near(input logic [WIDTH-1:0] v, input real e);
      real d;
      d = real'(sv(v)) - e;
      return d <= TOL && d >= -TOL;
   endfunction

   // Reference: clamp to [-1, 1] and evaluate the real trigonometric functions
   function automatic exp_t model(input logic [WIDTH-1:0] a, input int t);
      exp_t r;
      int v;
      v = sv(a);
      r.sat = v > ONE_I || v < -ONE_I;
      v = v > ONE_I ? ONE_I : v < -ONE_I ? -ONE_I : v;
      r.c = $cos(real'(v) / SCALE) * SCALE;
      r.s = $sin(real'(v) / SCALE) * SCALE;
      r.t = t;
      r.lit = lit_en;
      r.lc = lit_c;
      r.ls = lit_s;
      return r;
   endfunction

   int cyc = 0, acc_t = 0, last_acc = -1;
   bit pending = 0, prev_ov = 0, prev_b2b = 0, done_seen = 0;
   logic [WIDTH-1:0] h_c = '0, h_s = '0;
   logic h_sat = 0;
   exp_t e;

   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         check("reset_outputs", in_ready && !out_valid && out_cos == 0 && out_sin == 0 && !out_sat,
               $sformatf("rdy=%0b vld=%0b cos=%h sin=%h sat=%0b", in_ready, out_valid, out_cos, out_sin, out_sat),
               "rdy=1 vld=0 cos=0 sin=0 sat=0");
         q.delete();
         pending = 0;
         prev_ov = 0;
         h_c = '0;
         h_s = '0;
         h_sat = 0;
         last_acc = -1;
      end else begin
         check("in_ready", in_ready == !pending, $sformatf("%0b", in_ready), $sformatf("%0b", !pending));
         check("out_valid_busy", !out_valid || pending, $sformatf("%0b", out_valid), "0 while idle");
         if (out_valid && !prev_ov) begin
            if (q.size() == 0) check("spurious_result", 0, "result", "none pending");
            else begin
               e = q.pop_front();
               check("latency", cyc - e.t == ITER + 1, $sformatf("%0d", cyc - e.t), $sformatf("%0d", ITER + 1));
               check("cos", near(out_cos, e.c), $sformatf("%0d", sv(out_cos)), $sformatf("%0.1f", e.c));
               check("sin", near(out_sin, e.s), $sformatf("%0d", sv(out_sin)), $sformatf("%0.1f", e.s));
               check("sat", out_sat == e.sat, $sformatf("%0b", out_sat), $sformatf("%0b", e.sat));
               if (e.lit) begin
                  check("cos_literal", near(out_cos, real'(e.lc)), $sformatf("%h", out_cos), $sformatf("%0d", e.lc));
                  check("sin_literal", near(out_sin, real'(e.ls)), $sformatf("%h", out_sin), $sformatf("%0d", e.ls));
               end
            end
            h_c = out_cos;
            h_s = out_sin;
            h_sat = out_sat;
         end else
            check("hold", out_cos == h_c && out_sin == h_s && out_sat == h_sat,
                  $sformatf("%h/%h/%0b", out_cos, out_sin, out_sat), $sformatf("%h/%h/%0b", h_c, h_s, h_sat));
         if (out_valid && out_ready) pending = 0;
         if (pending && !out_valid && cyc - acc_t > ITER + 4) begin
            check("result_timeout", 0, "no out_valid", "out_valid");
            pending = 0;
         end
         if (b2b && !prev_b2b) last_acc = -1;
         if (in_valid && in_ready) begin
            if (b2b && last_acc >= 0)
               check("interval", cyc - last_acc == ITER + 2, $sformatf("%0d", cyc - last_acc), $sformatf("%0d", ITER + 2));
            last_acc = cyc;
            acc_t = cyc;
            pending = 1;
            q.push_back(model(in_angle, cyc));
         end
         if (done_flag && !done_seen) begin
            check("drained", q.size() == 0 && !pending, $sformatf("%0d left", q.size()), "0 left");
            done_seen = 1;
         end
         prev_ov = out_valid;
         prev_b2b = b2b;
      end
   end

   task automatic wait_ready();
      for (int n = 0; n < 100 && !in_ready; n++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [WIDTH-1:0] a);
      wait_ready();
      in_angle = a;
      in_valid = 1;
      @(posedge clk);
      #1 in_valid = 0;
   endtask

   task automatic directed(input logic [WIDTH-1:0] a, input bit lit, input int c, input int s);
      lit_en = lit;
      lit_c = c;
      lit_s = s;
      send(a);
      lit_en = 0;
      @(posedge clk);
      #1 wait_ready();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      bit acc;
      repeat (3) @(posedge clk);
      #1 reset_n = 1;
      @(posedge clk);
      #1;
      directed(24'h000000, 1, 4194304, 0);
      directed(24'h400000, 1, 2266192, 3529385);
      directed(24'hC00000, 1, 2266192, -3529385);
      directed(24'h600000, 1, 2266192, 3529385);
      directed(24'h400001, 0, 0, 0);
      directed(24'hBFFFFF, 0, 0, 0);
      directed(24'h3FFFFF, 0, 0, 0);
      directed(24'h800000, 0, 0, 0);
      // Consumer stall with ignored input pulses
      out_ready = 0;
      send(24'(int'($urandom_range(0, 24'h800000)) - ONE_I));
      for (int n = 0; n < 100 && !out_valid; n++) begin
         @(posedge clk);
         #1;
      end
      for (int k = 0; k < 5; k++) begin
         in_valid = k[0];
         in_angle = 24'($urandom);
         @(posedge clk);
         #1;
      end
      in_valid = 0;
      out_ready = 1;
      @(posedge clk);
      #1 wait_ready();
      // Abort mid-rotation
      send(24'h200000);
      repeat (10) @(posedge clk);
      #2 reset_n = 0;
      @(posedge clk);
      #1 reset_n = 1;
      directed(24'h400000, 1, 2266192, 3529385);
      // Back-to-back random angles, including clamped ones
      b2b = 1;
      in_valid = 1;
      for (int k = 0; k < 1000; k++) begin
         in_angle = 24'(int'($urandom_range(0, 24'hC00000)) - 24'h600000);
         acc = 0;
         for (int n = 0; n < 100 && !acc; n++) begin
            acc = in_ready;
            @(posedge clk);
            #1;
         end
      end
      in_valid = 0;
      b2b = 0;
      repeat (ITER + 4) @(posedge clk);
      #1 done_flag = 1;
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
